// File: rtl/control_unit.sv
// Instruction-sequencing FSM: fetch/decode/execute, ALU op select and datapath strobes.
// Latency: start at edge N -> FETCH1 from edge N; 3-5 cycles per instruction, outputs Moore.
// Backpressure: none; start sampled only in IDLE, ins only in DECODE, z_flag only in JMPZ.

package details;
    typedef enum logic [2:0] {
        idle_alu = 3'd0,
        clr_alu  = 3'd1,
        add_alu  = 3'd2,
        sub_alu  = 3'd3,
        mul_alu  = 3'd4,
        inc_alu  = 3'd5,
        pass_alu = 3'd6
    } alu_op_t;
endpackage

module control_unit
    import details::*;
#(
    parameter int INS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [INS_WIDTH-1:0] ins,
    input  logic                 z_flag,
    output alu_op_t              selectOp,
    output logic                 ac_load,
    output logic                 ir_load,
    output logic                 pc_inc,
    output logic                 pc_load,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ready,
    output logic                 done
);

    localparam logic [INS_WIDTH-1:0] OP_CLAC  = INS_WIDTH'(8'h01);
    localparam logic [INS_WIDTH-1:0] OP_LDAC  = INS_WIDTH'(8'h02);
    localparam logic [INS_WIDTH-1:0] OP_STAC  = INS_WIDTH'(8'h03);
    localparam logic [INS_WIDTH-1:0] OP_ADD   = INS_WIDTH'(8'h04);
    localparam logic [INS_WIDTH-1:0] OP_SUB   = INS_WIDTH'(8'h05);
    localparam logic [INS_WIDTH-1:0] OP_MUL   = INS_WIDTH'(8'h06);
    localparam logic [INS_WIDTH-1:0] OP_INCAC = INS_WIDTH'(8'h07);
    localparam logic [INS_WIDTH-1:0] OP_JUMP  = INS_WIDTH'(8'h08);
    localparam logic [INS_WIDTH-1:0] OP_JMPZ  = INS_WIDTH'(8'h09);
    localparam logic [INS_WIDTH-1:0] OP_ENDOP = INS_WIDTH'(8'hFF);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC,
        S_LOAD1, S_LOAD2, S_STORE, S_JUMP, S_JMPZ, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [INS_WIDTH-1:0] op_q, op_d;

    // State and latched-opcode registers; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state selection and Moore output decode from the registered state.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        selectOp  = idle_alu;
        ac_load   = 1'b0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ready     = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_d = S_FETCH1;
            end
            S_FETCH1: begin
                mem_read = 1'b1;
                state_d  = S_FETCH2;
            end
            S_FETCH2: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // EXEC works from this captured copy, so ins may move on afterwards.
                op_d = ins;
                case (ins)
                    OP_CLAC, OP_ADD, OP_SUB, OP_MUL, OP_INCAC: state_d = S_EXEC;
                    OP_LDAC:  state_d = S_LOAD1;
                    OP_STAC:  state_d = S_STORE;
                    OP_JUMP:  state_d = S_JUMP;
                    OP_JMPZ:  state_d = S_JMPZ;
                    OP_ENDOP: state_d = S_DONE;
                    default:  state_d = S_FETCH1;
                endcase
            end
            S_EXEC: begin
                ac_load = 1'b1;
                state_d = S_FETCH1;
                case (op_q)
                    OP_CLAC:  selectOp = clr_alu;
                    OP_ADD:   selectOp = add_alu;
                    OP_SUB:   selectOp = sub_alu;
                    OP_MUL:   selectOp = mul_alu;
                    OP_INCAC: selectOp = inc_alu;
                    default:  selectOp = idle_alu;
                endcase
            end
            S_LOAD1: begin
                mem_read = 1'b1;
                pc_inc   = 1'b1;
                state_d  = S_LOAD2;
            end
            S_LOAD2: begin
                selectOp = pass_alu;
                ac_load  = 1'b1;
                state_d  = S_FETCH1;
            end
            S_STORE: begin
                mem_write = 1'b1;
                state_d   = S_FETCH1;
            end
            S_JUMP: begin
                pc_load = 1'b1;
                state_d = S_FETCH1;
            end
            S_JMPZ: begin
                // Not taken still has to step over the operand word.
                pc_load = z_flag;
                pc_inc  = ~z_flag;
                state_d = S_FETCH1;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomised programs against an instruction-level micro-op table model.
// Latency: expected per-cycle output words queued at each instruction's FETCH1.
// Backpressure: none; one compare process checks every cycle while enabled.

module tb_control_unit;
    import details::*;

    logic       clk = 1'b0;
    logic       rst, start, z_flag;
    logic [7:0] ins;
    alu_op_t    selectOp;
    logic       ac_load, ir_load, pc_inc, pc_load, mem_read, mem_write, ready, done;

    control_unit #(.INS_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .ins(ins), .z_flag(z_flag),
        .selectOp(selectOp), .ac_load(ac_load), .ir_load(ir_load),
        .pc_inc(pc_inc), .pc_load(pc_load), .mem_read(mem_read),
        .mem_write(mem_write), .ready(ready), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        alu_op_t op;
        logic ac_load, ir_load, pc_inc, pc_load, mem_read, mem_write, ready, done;
    } obs_t;

    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;
    obs_t exp_q[$];
    logic [7:0] prog_q[$];
    logic       zprog_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // Number of cycles an instruction occupies, FETCH1 up to the next FETCH1.
    function automatic int ilen(input logic [7:0] i);
        case (i)
            8'h01, 8'h04, 8'h05, 8'h06, 8'h07: return 4;
            8'h02: return 5;
            8'h03, 8'h08, 8'h09, 8'hFF: return 4;
            default: return 3;
        endcase
    endfunction

    // Output word expected in cycle j of instruction i.
    function automatic obs_t micro(input logic [7:0] i, input logic z, input int j);
        obs_t o;
        o = '0;
        o.op = idle_alu;
        if (j == 0) o.mem_read = 1'b1;
        else if (j == 1) begin o.ir_load = 1'b1; o.pc_inc = 1'b1; end
        else if (j == 3) begin
            case (i)
                8'h01: begin o.op = clr_alu; o.ac_load = 1'b1; end
                8'h04: begin o.op = add_alu; o.ac_load = 1'b1; end
                8'h05: begin o.op = sub_alu; o.ac_load = 1'b1; end
                8'h06: begin o.op = mul_alu; o.ac_load = 1'b1; end
                8'h07: begin o.op = inc_alu; o.ac_load = 1'b1; end
                8'h02: begin o.mem_read = 1'b1; o.pc_inc = 1'b1; end
                8'h03: o.mem_write = 1'b1;
                8'h08: o.pc_load = 1'b1;
                8'h09: begin o.pc_load = z; o.pc_inc = ~z; end
                8'hFF: o.done = 1'b1;
                default: ;
            endcase
        end else if (j == 4) begin
            o.op = pass_alu; o.ac_load = 1'b1;
        end
        return o;
    endfunction

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.op = idle_alu;
        o.ready = 1'b1;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.op = selectOp;   o.ac_load = ac_load;   o.ir_load = ir_load;
        o.pc_inc = pc_inc; o.pc_load = pc_load;   o.mem_read = mem_read;
        o.mem_write = mem_write; o.ready = ready; o.done = done;
        return o;
    endfunction

    // Per-cycle comparison against the model; an empty queue means IDLE.
    always @(negedge clk) begin
        obs_t e, g;
        if (chk_en) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_obs();
            g = dut_obs();
            chk("cycle", 32'(g), 32'(e));
            chk("pc_excl", {31'b0, pc_inc & pc_load}, 32'd0);
            chk("mem_excl", {31'b0, mem_read & mem_write}, 32'd0);
        end
    end

    // Launch from IDLE and run prog_q followed by ENDOP; ins valid only in DECODE.
    task automatic run_list();
        logic [7:0] iv;
        logic       zv;
        int         n, len;
        n = prog_q.size();
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k <= n; k++) begin
            iv  = (k < n) ? prog_q[k] : 8'hFF;
            zv  = (k < n) ? zprog_q[k] : 1'b0;
            len = ilen(iv);
            for (int j = 0; j < len; j++) exp_q.push_back(micro(iv, zv, j));
            for (int j = 0; j < len; j++) begin
                ins    = (j == 2) ? iv : 8'($urandom);
                z_flag = (j == 3) ? zv : 1'($urandom);
                start  = 1'($urandom);
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        ins   = 8'($urandom);
        prog_q.delete();
        zprog_q.delete();
    endtask

    // Start instruction iv and assert reset during its cycle jr.
    task automatic rst_mid(input logic [7:0] iv, input int jr);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j <= jr; j++) exp_q.push_back(micro(iv, 1'b0, j));
        for (int j = 0; j <= jr; j++) begin
            ins    = (j == 2) ? iv : 8'($urandom);
            z_flag = 1'b0;
            if (j == jr) rst = 1'b1;
            if (j == 0) begin
                @(negedge clk);
                chk("start_latency_mem_read", {31'b0, mem_read}, 32'd1);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_ac_load", {31'b0, ac_load}, 32'd0);
        chk("rst_mid_ready", {31'b0, ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] dir[12];
        logic       dz[12];
        int         r, n;
        rst = 1'b1; start = 1'b0; ins = 8'h00; z_flag = 1'b0;

        // Hand-computed pins on the model itself.
        chk("model_len_add",  32'(ilen(8'h04)), 32'd4);
        chk("model_len_ldac", 32'(ilen(8'h02)), 32'd5);
        chk("model_len_undef", 32'(ilen(8'h3A)), 32'd3);
        chk("model_len_endop", 32'(ilen(8'hFF)), 32'd4);
        chk("model_exec_add", 32'(micro(8'h04, 1'b0, 3)), 32'h280);
        chk("model_jmpz_taken", 32'(micro(8'h09, 1'b1, 3)), 32'h010);
        chk("model_jmpz_fall", 32'(micro(8'h09, 1'b0, 3)), 32'h020);
        chk("model_ldac_load2", 32'(micro(8'h02, 1'b0, 4)), 32'h680);
        chk("model_endop_done", 32'(micro(8'hFF, 1'b0, 3)), 32'h001);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'b0, ready}, 32'd1);
        chk("reset_selectOp", 32'(selectOp), 32'(idle_alu));
        chk("reset_strobes", {25'b0, ac_load, ir_load, pc_inc, pc_load, mem_read, mem_write, done}, 32'd0);
        chk_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Directed program: every opcode class, JMPZ both ways, undefined and NOP.
        dir = '{8'h04, 8'h01, 8'h05, 8'h06, 8'h07, 8'h02, 8'h03, 8'h08, 8'h09, 8'h09, 8'h3A, 8'h00};
        dz  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 12; k++) begin
            prog_q.push_back(dir[k]);
            zprog_q.push_back(dz[k]);
        end
        run_list();

        rst_mid(8'h04, 3);
        rst_mid(8'h02, 3);

        // Reset wins over start in the same cycle.
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_prio_ready", {31'b0, ready}, 32'd1);
        chk("rst_prio_mem_read", {31'b0, mem_read}, 32'd0);
        @(posedge clk); #1;

        repeat (30) begin
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 11);
                prog_q.push_back(r < 10 ? 8'(r) : 8'($urandom_range(8'h0A, 8'hFE)));
                zprog_q.push_back(1'($urandom));
            end
            run_list();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing FSM for one processing core. It steps through fetch, decode and execute, and drives the core's `alu_op_t` select into the ALU. It also drives the load, increment and memory strobes that move operands into and out of the ALU. It sits directly upstream of the ALU and consumes the ALU zero flag for conditional branches.

## Interface
Parameters:
- `INS_WIDTH`, default 8: opcode width of the instruction register.

Ports (synchronous active-high reset, single clock):
- `clk` in 1: core clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin execution from the current PC. Sampled only in IDLE.
- `ins` in `INS_WIDTH`: opcode from the instruction register, valid from DECODE onward.
- `z_flag` in 1: ALU result-zero flag, sampled in JMPZ.
- `selectOp` out `alu_op_t`: ALU operation, from package `details`.
- `ac_load` out 1: accumulator captures ALU output `c` this edge.
- `ir_load` out 1: instruction register captures memory data.
- `pc_inc` out 1: program counter increments.
- `pc_load` out 1: program counter loads the operand word (jump target).
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe (store accumulator).
- `ready` out 1: high only in IDLE.
- `done` out 1: one-cycle pulse after ENDOP.

## Operation
- Opcodes (`ins` value):
  - NOP 0x00, CLAC 0x01, LDAC 0x02, STAC 0x03.
  - ADD 0x04, SUB 0x05, MUL 0x06, INCAC 0x07.
  - JUMP 0x08, JMPZ 0x09, ENDOP 0xFF.
  - Any other value executes as NOP.
- States: IDLE, FETCH1, FETCH2, DECODE, EXEC, LOAD1, LOAD2, STORE, JUMP, JMPZ, DONE.
- Outputs are Moore, decoded from the registered state. Latch `ins` into an internal opcode register in DECODE; EXEC uses the latched value.
- Default in every state: `selectOp`=`idle_alu`, all strobes 0, `ready`=0, `done`=0.
- IDLE: `ready`=1. Go to FETCH1 if `start`=1, else stay.
- FETCH1: `mem_read`=1, then FETCH2.
- FETCH2: `ir_load`=1 and `pc_inc`=1, then DECODE.
- DECODE: no strobes. Next state by opcode:
  - CLAC, ADD, SUB, MUL, INCAC → EXEC.
  - LDAC → LOAD1.
  - STAC → STORE.
  - JUMP → JUMP.
  - JMPZ → JMPZ.
  - ENDOP → DONE.
  - NOP or undefined → FETCH1.
- EXEC: `ac_load`=1, then FETCH1. `selectOp` by opcode:
  - CLAC → `clr_alu`
  - ADD → `add_alu`
  - SUB → `sub_alu`
  - MUL → `mul_alu`
  - INCAC → `inc_alu`
- LOAD1: `mem_read`=1 and `pc_inc`=1, then LOAD2.
- LOAD2: `selectOp`=`pass_alu` and `ac_load`=1, then FETCH1.
- STORE: `mem_write`=1, then FETCH1.
- JUMP: `pc_load`=1, then FETCH1.
- JMPZ:
  - `z_flag`=1: `pc_load`=1.
  - `z_flag`=0: `pc_inc`=1, skipping the operand word.
  - Either way, then FETCH1.
- DONE: `done`=1, then IDLE.
- `start` outside IDLE is ignored. `start` held high through DONE re-launches from IDLE on the following cycle.

## Timing
- Reset: at the first rising edge with `rst`=1, state becomes IDLE. Outputs: `ready`=1, `selectOp`=`idle_alu`, all other outputs 0.
- Reset mid-instruction aborts immediately; no strobe is asserted in the cycle after the reset edge. `rst` has priority over `start`.
- Start latency: `start` high at edge N puts the FSM in FETCH1 from edge N, so `mem_read` is high in cycle N+1.
- Per-instruction cycles, counted from FETCH1 to the next FETCH1:
  - ALU op: 4
  - LDAC: 5
  - STAC, JUMP, JMPZ: 4
  - NOP or undefined: 3
  - ENDOP: 4 cycles to IDLE, with `done` in the 4th.
- `z_flag` is sampled in the JMPZ cycle and reflects the ALU result of the previous instruction. The accumulator stays stable through FETCH/DECODE.
- Strobe exclusivity: `pc_inc` and `pc_load` are never high together. `mem_read` and `mem_write` are never high together.

## Test plan
- Reset, then idle: hold `rst` 2 cycles with `start`=0 → `ready`=1, `selectOp`=`idle_alu`, all strobes 0. FSM stays IDLE for 5 cycles.
- ADD flow: `start` pulse, `ins`=0x04 → cycles: FETCH1 `mem_read`; FETCH2 `ir_load`+`pc_inc`; DECODE; EXEC `selectOp`=`add_alu`+`ac_load`; then FETCH1.
- All ALU ops: `ins`=0x01, 0x05, 0x06, 0x07 → EXEC `selectOp` = `clr_alu`, `sub_alu`, `mul_alu`, `inc_alu` respectively.
- LDAC: `ins`=0x02 → LOAD1 `mem_read`+`pc_inc`, LOAD2 `pass_alu`+`ac_load`; 5 cycles total.
- JMPZ both ways: `ins`=0x09 with `z_flag`=1 → `pc_load`=1, `pc_inc`=0. With `z_flag`=0 → `pc_inc`=1, `pc_load`=0.
- ENDOP, undefined opcode and reset:
  - `ins`=0xFF → one-cycle `done`, then `ready`=1.
  - `ins`=0x3A → DECODE returns to FETCH1 with no strobes.
  - `rst` in EXEC → next cycle IDLE, `ac_load`=0.
